// File: rtl/vga_display_param.sv
// rtl/vga_display_param.sv - Parametrised VGA raster controller with RAM-latency compensation and test patterns
// Counters feed stage A (RAM addresses); sync/select info rides a delay line so it lines up with the returned pixel data.
module vga_display_param #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CW       = 4,
  parameter int COL_W    = 10,
  parameter int ROW_W    = 9,
  parameter int SCALE    = 0,
  parameter int RD_LAT   = 1
) (
  input  logic              vga_clk,
  input  logic              clrn,
  input  logic [3*CW-1:0]   d_in,
  input  logic [1:0]        mode,
  input  logic [3*CW-1:0]   bg_color,
  output logic [ROW_W-1:0]  row_addr,
  output logic [COL_W-1:0]  col_addr,
  output logic              rdn,
  output logic [CW-1:0]     r,
  output logic [CW-1:0]     g,
  output logic [CW-1:0]     b,
  output logic              hs,
  output logic              vs,
  output logic              de,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam logic HS_ACT = HS_POL[0];
  localparam logic VS_ACT = VS_POL[0];

  // Delay-line word: {act, hs, vs, fs, sel[1:0], pattern colour}
  localparam int PAT_W   = 3 * CW;
  localparam int SEL_LSB = PAT_W;
  localparam int FS_BIT  = PAT_W + 2;
  localparam int VS_BIT  = PAT_W + 3;
  localparam int HS_BIT  = PAT_W + 4;
  localparam int ACT_BIT = PAT_W + 5;
  localparam int INFO_W  = PAT_W + 6;
  localparam logic [INFO_W-1:0] INFO_RST = {1'b0, ~HS_ACT, ~VS_ACT, 1'b0, 2'b00, {PAT_W{1'b0}}};

  if (SCALE < 0 || SCALE > 2) begin : g_bad_scale
    $error("vga_display_param: SCALE must be in 0..2");
  end
  if (RD_LAT < 0 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("vga_display_param: RD_LAT must be in 0..4");
  end

  logic [HW-1:0]      h_cnt_q, h_cnt_d;
  logic [VW-1:0]      v_cnt_q, v_cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic [COL_W-1:0]   col_addr_q, col_addr_d;
  logic [ROW_W-1:0]   row_addr_q, row_addr_d;
  logic               rdn_q, rdn_d;
  logic [PAT_W-1:0]   rgb_q, rgb_d;
  logic [INFO_W-1:0]  stg_q [0:RD_LAT+1];
  logic [INFO_W-1:0]  stg_d [0:RD_LAT+1];

  logic [31:0]        h_ext, v_ext;
  logic               act_raw, hs_raw, vs_raw, fs_raw;
  logic [1:0]         mode_eff;
  logic [2:0]         bar;
  logic [PAT_W-1:0]   bar_col, chk_col, pat_col;
  logic [INFO_W-1:0]  pre;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == HW'(H_TOTAL - 1)) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == VW'(V_TOTAL - 1)) ? '0 : v_cnt_q + VW'(1);
    end else begin
      h_cnt_d = h_cnt_q + HW'(1);
    end
  end

  always_comb begin
    h_ext   = 32'(h_cnt_q);
    v_ext   = 32'(v_cnt_q);
    act_raw = (h_ext < 32'(H_ACTIVE)) && (v_ext < 32'(V_ACTIVE));
    hs_raw  = (h_ext >= 32'(H_ACTIVE + H_FP) && h_ext < 32'(H_ACTIVE + H_FP + H_SYNC)) ? HS_ACT : ~HS_ACT;
    vs_raw  = (v_ext >= 32'(V_ACTIVE + V_FP) && v_ext < 32'(V_ACTIVE + V_FP + V_SYNC)) ? VS_ACT : ~VS_ACT;
    fs_raw  = (h_cnt_q == '0) && (v_cnt_q == '0);
    // The first pixel of a frame already uses the freshly sampled mode
    mode_eff = fs_raw ? mode : mode_q;
    mode_d   = mode_eff;
  end

  always_comb begin
    bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (h_ext >= 32'(k * H_ACTIVE / 8)) bar = 3'(k);
    end
    bar_col = {{CW{~bar[0]}}, {CW{~bar[2]}}, {CW{~bar[1]}}};
    chk_col = {PAT_W{h_ext[5] ^ v_ext[5]}};
    pat_col = (mode_eff == 2'b01) ? bar_col : (mode_eff == 2'b10) ? chk_col : '0;
  end

  always_comb begin
    col_addr_d = COL_W'(h_ext >> SCALE);
    row_addr_d = ROW_W'(v_ext >> SCALE);
    rdn_d      = ~act_raw;
    stg_d[0]   = {act_raw, hs_raw, vs_raw, fs_raw, mode_eff, pat_col};
    for (int i = 1; i <= RD_LAT + 1; i++) begin
      stg_d[i] = stg_q[i-1];
    end
  end

  // pre is the word entering the last stage, so colour lands together with sync
  always_comb begin
    pre = stg_q[RD_LAT];
    rgb_d = '0;
    if (pre[ACT_BIT]) begin
      case (pre[SEL_LSB +: 2])
        2'b00:   rgb_d = d_in;
        2'b11:   rgb_d = bg_color;
        default: rgb_d = pre[PAT_W-1:0];
      endcase
    end
  end

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      mode_q     <= 2'b00;
      col_addr_q <= '0;
      row_addr_q <= '0;
      rdn_q      <= 1'b1;
      rgb_q      <= '0;
      for (int i = 0; i <= RD_LAT + 1; i++) begin
        stg_q[i] <= INFO_RST;
      end
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      mode_q     <= mode_d;
      col_addr_q <= col_addr_d;
      row_addr_q <= row_addr_d;
      rdn_q      <= rdn_d;
      rgb_q      <= rgb_d;
      for (int i = 0; i <= RD_LAT + 1; i++) begin
        stg_q[i] <= stg_d[i];
      end
    end
  end

  assign row_addr    = row_addr_q;
  assign col_addr    = col_addr_q;
  assign rdn         = rdn_q;
  assign {b, g, r}   = rgb_q;
  assign de          = stg_q[RD_LAT+1][ACT_BIT];
  assign hs          = stg_q[RD_LAT+1][HS_BIT];
  assign vs          = stg_q[RD_LAT+1][VS_BIT];
  assign frame_start = stg_q[RD_LAT+1][FS_BIT];

endmodule

// File: tb/tb_vga_display_param.sv
// tb/tb_vga_display_param.sv - Directed bench for vga_display_param
// u0: default timing; u1: small raster, RD_LAT=2 with RAM model; u2: small raster, SCALE=1.
module tb_vga_display_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clrn;
  logic [1:0]  mode1;
  logic [11:0] bg1;
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [8:0]  row0, row1, row2;
  logic [9:0]  col0, col1, col2;
  logic        rdn0, rdn1, rdn2;
  logic [3:0]  r0, g0, b0, r1, g1, b1, r2, g2, b2;
  logic        hs0, vs0, de0, fs0, hs1, vs1, de1, fs1, hs2, vs2, de2, fs2;
  logic [11:0] ram_q1, ram_q2;
  logic [11:0] rgb1;
  assign rgb1 = {b1, g1, r1};

  // Two-cycle latency RAM returning {row[3:0], col[7:0]}
  always @(posedge clk) begin
    ram_q1 <= {row1[3:0], col1[7:0]};
    ram_q2 <= ram_q1;
  end

  vga_display_param u0 (
    .vga_clk(clk), .clrn(clrn), .d_in(12'h000), .mode(2'b00), .bg_color(12'h000),
    .row_addr(row0), .col_addr(col0), .rdn(rdn0), .r(r0), .g(g0), .b(b0),
    .hs(hs0), .vs(vs0), .de(de0), .frame_start(fs0)
  );

  vga_display_param #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(3), .RD_LAT(2)
  ) u1 (
    .vga_clk(clk), .clrn(clrn), .d_in(ram_q2), .mode(mode1), .bg_color(bg1),
    .row_addr(row1), .col_addr(col1), .rdn(rdn1), .r(r1), .g(g1), .b(b1),
    .hs(hs1), .vs(vs1), .de(de1), .frame_start(fs1)
  );

  vga_display_param #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(3), .SCALE(1), .RD_LAT(1)
  ) u2 (
    .vga_clk(clk), .clrn(clrn), .d_in(12'h000), .mode(2'b00), .bg_color(12'h000),
    .row_addr(row2), .col_addr(col2), .rdn(rdn2), .r(r2), .g(g2), .b(b2),
    .hs(hs2), .vs(vs2), .de(de2), .frame_start(fs2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after edge n, counting edges since reset release
  task automatic go(input int n);
    while (cyc < n) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  initial begin
    clrn  = 1'b0;
    mode1 = 2'b00;
    bg1   = 12'h000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_row", 32'(row1), 32'h0);
    chk("rst_col", 32'(col1), 32'h0);
    chk("rst_rdn", 32'(rdn1), 32'h1);
    chk("rst_rgb", 32'(rgb1), 32'h0);
    chk("rst_de", 32'(de1), 32'h0);
    chk("rst_fs", 32'(fs1), 32'h0);
    chk("rst_hs", 32'(hs1), 32'h1);
    chk("rst_vs", 32'(vs1), 32'h1);
    chk("rst_hs0", 32'(hs0), 32'h1);
    @(negedge clk);
    clrn = 1'b1;
    cyc = 0;

    go(1);     chk("s1_col_e1", 32'(col2), 32'd0); chk("s1_rdn_e1", 32'(rdn2), 32'd0);
    go(2);     chk("s1_col_e2", 32'(col2), 32'd0);
    go(3);     chk("s1_col_e3", 32'(col2), 32'd1);
    chk("u0_fs_e3", 32'(fs0), 32'd1); chk("u0_de_e3", 32'(de0), 32'd1);
    chk("u1_fs_e3", 32'(fs1), 32'd0);
    go(4);     chk("u1_fs_e4", 32'(fs1), 32'd1); chk("u1_de_e4", 32'(de1), 32'd1);
    chk("ram_px00", 32'(rgb1), 32'h000); chk("u0_fs_e4", 32'(fs0), 32'd0);
    go(5);     chk("u1_fs_e5", 32'(fs1), 32'd0);
    go(41);    chk("ram_px0_37", 32'(rgb1), 32'h025);
    go(64);    chk("s1_col_max", 32'(col2), 32'd31); chk("s1_rdn_act", 32'(rdn2), 32'd0);
    go(65);    chk("s1_col_hold", 32'(col2), 32'd32); chk("s1_rdn_blank", 32'(rdn2), 32'd1);
    go(68);    chk("ram_blank_de", 32'(de1), 32'd0); chk("ram_blank_rgb", 32'(rgb1), 32'h0);
    go(81);    chk("s1_row_l1", 32'(row2), 32'd0);
    go(161);   chk("s1_row_l2", 32'(row2), 32'd1);
    go(467);   chk("ram_px5_63", 32'(rgb1), 32'h53F);
    go(642);   chk("u0_de_last", 32'(de0), 32'd1);
    go(643);   chk("u0_de_off", 32'(de0), 32'd0);
    go(658);   chk("u0_hs_pre", 32'(hs0), 32'd1);
    go(659);   chk("u0_hs_fall", 32'(hs0), 32'd0);
    go(754);   chk("u0_hs_end", 32'(hs0), 32'd0);
    go(755);   chk("u0_hs_rise", 32'(hs0), 32'd1);
    go(803);   chk("u0_de_line1", 32'(de0), 32'd1);
    go(1054);  chk("ram_px13_10", 32'(rgb1), 32'hD0A);
    go(1458);  chk("u0_hs_pre2", 32'(hs0), 32'd1);
    go(1459);  chk("u0_hs_fall2", 32'(hs0), 32'd0);
    go(3766);  chk("s1_row_max", 32'(row2), 32'd23); chk("s1_col_l47", 32'(col2), 32'd2);
    go(4003);  chk("u1_vs_pre", 32'(vs1), 32'd1);
    go(4004);  chk("u1_vs_fall", 32'(vs1), 32'd0);
    mode1 = 2'b01;
    go(4163);  chk("u1_vs_end", 32'(vs1), 32'd0);
    go(4164);  chk("u1_vs_rise", 32'(vs1), 32'd1);

    go(4404);  chk("bar_px0", 32'(rgb1), 32'hFFF); chk("bar_fs", 32'(fs1), 32'd1);
    go(4412);  chk("bar_px8", 32'(rgb1), 32'h0FF);
    go(4420);  chk("bar_px16", 32'(rgb1), 32'hFF0);
    go(4459);  chk("bar_px55", 32'(rgb1), 32'hF00);
    go(4460);  chk("bar_px56", 32'(rgb1), 32'h000);
    go(4467);  chk("bar_px63", 32'(rgb1), 32'h000); chk("bar_de63", 32'(de1), 32'd1);
    go(4474);  chk("bar_hblank", 32'(rgb1), 32'h000); chk("bar_hblank_de", 32'(de1), 32'd0);
    go(8414);  chk("bar_vblank", 32'(rgb1), 32'h000); chk("bar_vblank_de", 32'(de1), 32'd0);
    mode1 = 2'b11;
    bg1   = 12'h0A5;
    go(8809);  chk("bg_px0_5", 32'(rgb1), 32'h0A5);
    go(10404);
    mode1 = 2'b10;
    go(10500); chk("bg_hold_l21", 32'(rgb1), 32'h0A5);
    go(11207); chk("bg_hold_l30", 32'(rgb1), 32'h0A5);
    go(13209); chk("chk_px0_5", 32'(rgb1), 32'h000); chk("chk_de", 32'(de1), 32'd1);
    go(13236); chk("chk_px0_32", 32'(rgb1), 32'hFFF);
    go(15854); chk("chk_px33_10", 32'(rgb1), 32'hFFF);
    go(15884); chk("chk_px33_40", 32'(rgb1), 32'h000);

    go(20020);
    clrn = 1'b0;
    #1;
    chk("mid_rst_rdn", 32'(rdn1), 32'd1);
    chk("mid_rst_row", 32'(row1), 32'd0);
    chk("mid_rst_col", 32'(col1), 32'd0);
    chk("mid_rst_rgb", 32'(rgb1), 32'h0);
    chk("mid_rst_de", 32'(de1), 32'd0);
    chk("mid_rst_hs", 32'(hs1), 32'd1);
    chk("mid_rst_vs", 32'(vs1), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_hold_de", 32'(de1), 32'd0);
    chk("mid_rst_hold_fs", 32'(fs1), 32'd0);
    @(negedge clk);
    clrn = 1'b1;
    cyc = 0;
    go(3);     chk("rel_fs_e3", 32'(fs1), 32'd0); chk("rel_hs_e3", 32'(hs1), 32'd1);
    go(4);     chk("rel_fs_e4", 32'(fs1), 32'd1); chk("rel_de_e4", 32'(de1), 32'd1);
    chk("rel_rgb_e4", 32'(rgb1), 32'h000);
    go(5);     chk("rel_fs_e5", 32'(fs1), 32'd0);
    for (int i = 6; i < 72; i++) begin
      go(i);
      chk("rel_no_hs", 32'(hs1), 32'd1);
    end
    go(72);    chk("rel_hs_fall", 32'(hs1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
